// File: rtl/snn_readout_pkg.sv
// Shared types and helpers for the spike-count readout block.
// Holds the readout FSM state encoding, the default geometry constants and
// the saturating-increment helper used by the per-neuron counters.
package snn_readout_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } readout_state_t;

   localparam int N_DEF  = 96;
   localparam int CW_DEF = 8;
   localparam int TW_DEF = 16;

   // Adds one spike bit to a count that is cw bits wide, clamping at 2^cw-1.
   // The one-bit-wider sum exposes the carry so a full counter never wraps.
   function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                           input logic        inc,
                                           input int unsigned cw);
      logic [32:0] sum;
      logic [32:0] max_val;
      max_val = (33'd1 << cw) - 33'd1;
      sum     = {1'b0, count} + {32'd0, inc};
      if (sum > max_val) begin
         sat_inc = max_val[31:0];
      end else begin
         sat_inc = sum[31:0];
      end
   endfunction

endpackage

// File: rtl/spike_argmax_tracker.sv
// Running argmax over the readout beats (built only when SPK_ARGMAX_EN is defined).
// A beat replaces the current winner only when its count is strictly larger,
// so ties keep the earlier (lower) neuron index.
import snn_readout_pkg::*;

module spike_argmax_tracker #(
   parameter int CW = CW_DEF,
   parameter int IW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          beat_valid,
   input  logic [IW-1:0] beat_idx,
   input  logic [CW-1:0] beat_count,
   output logic [IW-1:0] winner_idx,
   output logic [CW-1:0] winner_count
);

   // Track the strictly-largest count seen since the last clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         winner_idx   <= '0;
         winner_count <= '0;
      end else if (clear) begin
         winner_idx   <= '0;
         winner_count <= '0;
      end else if (beat_valid && (beat_count > winner_count)) begin
         winner_idx   <= beat_idx;
         winner_count <= beat_count;
      end
   end

endmodule

// File: rtl/spike_count_readout.sv
// Spike-count readout: accumulates per-neuron spike counts over a window of
// valid ticks, then streams one count per beat on a valid/ready interface.
// Optional feature macro: SPK_ARGMAX_EN adds an argmax (classification) tracker;
// without it winner_idx/winner_count are constant zero.
import snn_readout_pkg::*;

module spike_count_readout #(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [TW-1:0]          win_len,
   input  logic                   spk_valid,
   input  logic [N-1:0]           spikes_vec,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(N)-1:0]   out_idx,
   output logic [CW-1:0]          out_count,
   output logic                   out_last,
   output logic                   win_done,
   output logic [$clog2(N)-1:0]   winner_idx,
   output logic [CW-1:0]          winner_count
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   readout_state_t state;
   logic [CW-1:0]  counts [N];
   logic [TW-1:0]  len_q;
   logic [TW-1:0]  tick_cnt;
   logic [IW-1:0]  rd_idx;
   logic [IW-1:0]  next_idx;
   logic           start_ok;

   assign start_ok = (state == ST_IDLE) && start;
   assign next_idx = rd_idx + IW'(1);

   // Per-neuron counters: cleared by an accepted start, bumped in parallel on valid ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < N; n++) begin
            counts[n] <= '0;
         end
      end else if (start_ok) begin
         for (int n = 0; n < N; n++) begin
            counts[n] <= '0;
         end
      end else if ((state == ST_ACCUM) && spk_valid) begin
         for (int n = 0; n < N; n++) begin
            counts[n] <= CW'(sat_inc(32'(counts[n]), spikes_vec[n], CW));
         end
      end
   end

   // Window/readout FSM with all stream outputs registered (no ready-to-output path).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         tick_cnt  <= '0;
         rd_idx    <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
         win_done  <= 1'b0;
      end else begin
         win_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q     <= win_len;
                  tick_cnt  <= '0;
                  rd_idx    <= '0;
                  busy      <= 1'b1;
                  out_idx   <= '0;
                  out_count <= '0;
                  out_last  <= 1'b0;
                  state     <= (win_len == '0) ? ST_DRAIN : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (spk_valid) begin
                  tick_cnt <= tick_cnt + TW'(1);
                  if (tick_cnt == (len_q - TW'(1))) begin
                     rd_idx <= '0;
                     state  <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_idx   <= rd_idx;
                  out_count <= counts[rd_idx];
                  out_last  <= (rd_idx == LAST_IDX);
               end else if (out_ready) begin
                  if (rd_idx == LAST_IDX) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_idx   <= '0;
                     out_count <= '0;
                     win_done  <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     rd_idx    <= next_idx;
                     out_idx   <= next_idx;
                     out_count <= counts[next_idx];
                     out_last  <= (next_idx == LAST_IDX);
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SPK_ARGMAX_EN
   logic beat_fire;
   assign beat_fire = (state == ST_DRAIN) && out_valid && out_ready;

   spike_argmax_tracker #(
      .CW (CW),
      .IW (IW)
   ) u_argmax (
      .clk          (clk),
      .rst          (rst),
      .clear        (start_ok),
      .beat_valid   (beat_fire),
      .beat_idx     (out_idx),
      .beat_count   (out_count),
      .winner_idx   (winner_idx),
      .winner_count (winner_count)
   );
`else
   assign winner_idx   = '0;
   assign winner_count = '0;
`endif

endmodule

// File: tb/tb_spike_count_readout.sv
// Directed testbench for spike_count_readout (default geometry N=96, CW=8, TW=16).
// A small reference model keeps the expected per-neuron counts for each window.
module tb_spike_count_readout;

   localparam int N  = 96;
   localparam int CW = 8;
   localparam int TW = 16;
   localparam int IW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [TW-1:0] win_len;
   logic          spk_valid;
   logic [N-1:0]  spikes_vec;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_idx;
   logic [CW-1:0] out_count;
   logic          out_last;
   logic          win_done;
   logic [IW-1:0] winner_idx;
   logic [CW-1:0] winner_count;

   int checks   = 0;
   int failures = 0;
   int exp_cnt [N];
   int got_cnt [N];
   int model_len;
   int model_ticks;

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   spike_count_readout #(.N(N), .CW(CW), .TW(TW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .win_len      (win_len),
      .spk_valid    (spk_valid),
      .spikes_vec   (spikes_vec),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_idx      (out_idx),
      .out_count    (out_count),
      .out_last     (out_last),
      .win_done     (win_done),
      .winner_idx   (winner_idx),
      .winner_count (winner_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   // Pulse start from a negedge and reset the reference model for the new window.
   task automatic startWindow(input int len);
      for (int n = 0; n < N; n++) begin
         exp_cnt[n] = 0;
         got_cnt[n] = -1;
      end
      model_len   = len;
      model_ticks = 0;
      start   = 1'b1;
      win_len = TW'(len);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Present one cycle of spike input (called at a negedge, returns at the next negedge).
   task automatic applyStimulus(input logic valid, input logic [N-1:0] vec);
      spk_valid  = valid;
      spikes_vec = vec;
      if (valid && (model_ticks < model_len)) begin
         for (int n = 0; n < N; n++) begin
            if (vec[n] && (exp_cnt[n] < 255)) exp_cnt[n]++;
         end
         model_ticks++;
      end
      @(posedge clk);
      @(negedge clk);
      spk_valid  = 1'b0;
      spikes_vec = '0;
   endtask

   // Consume beats with out_ready high pct% of cycles, checking order, stability and values.
   task automatic drainBeats(input int pct, input int stop_at);
      int            beats;
      int            cyc;
      logic          rdy;
      logic          stalled;
      logic [IW-1:0] st_idx;
      logic [CW-1:0] st_cnt;
      beats   = 0;
      cyc     = 0;
      stalled = 1'b0;
      st_idx  = '0;
      st_cnt  = '0;
      while ((beats < stop_at) && (cyc < 3000)) begin
         if (stalled) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_idx", 32'(out_idx), 32'(st_idx));
            checkOutput("stall_count", 32'(out_count), 32'(st_cnt));
         end
         rdy = ($urandom_range(99, 0) < pct);
         out_ready = rdy;
         stalled = 1'b0;
         if (out_valid && rdy) begin
            checkOutput("beat_idx", 32'(out_idx), 32'(beats));
            checkOutput("beat_last", 32'(out_last), 32'(beats == N - 1));
            checkOutput("beat_count", 32'(out_count), 32'(exp_cnt[beats]));
            got_cnt[beats] = int'(out_count);
            beats++;
         end else if (out_valid) begin
            stalled = 1'b1;
            st_idx  = out_idx;
            st_cnt  = out_count;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      checkOutput("beat_total", 32'(beats), 32'(stop_at));
      if (stop_at == N) begin
         out_ready = 1'b0;
         checkOutput("win_done_pulse", 32'(win_done), 32'd1);
         checkOutput("done_valid_low", 32'(out_valid), 32'd0);
         checkOutput("done_busy", 32'(busy), 32'd1);
         @(negedge clk);
         checkOutput("win_done_clear", 32'(win_done), 32'd0);
         checkOutput("idle_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      logic [N-1:0] v;
      logic         pat [7];
      rst        = 1'b1;
      start      = 1'b0;
      win_len    = '0;
      spk_valid  = 1'b0;
      spikes_vec = '0;
      out_ready  = 1'b0;
      model_len  = 0;
      model_ticks = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_last", 32'(out_last), 32'd0);
      checkOutput("rst_done", 32'(win_done), 32'd0);
      checkOutput("rst_idx", 32'(out_idx), 32'd0);
      checkOutput("rst_count", 32'(out_count), 32'd0);
      checkOutput("rst_widx", 32'(winner_idx), 32'd0);
      checkOutput("rst_wcnt", 32'(winner_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] window of 5, neurons 3 and 10");
      startWindow(5);
      for (int t = 0; t < 5; t++) begin
         v = '0;
         v[3] = 1'b1;
         if (t == 0 || t == 2) v[10] = 1'b1;
         applyStimulus(1'b1, v);
      end
      drainBeats(100, N);
      checkOutput("w5_n3", 32'(got_cnt[3]), 32'd5);
      checkOutput("w5_n10", 32'(got_cnt[10]), 32'd2);
      checkOutput("w5_n4", 32'(got_cnt[4]), 32'd0);

      $display("[TB] window of 300, saturation, 30%% ready");
      startWindow(300);
      for (int t = 0; t < 300; t++) begin
         v = '0;
         v[0] = 1'b1;
         if (t % 2 == 0) v[1] = 1'b1;
         applyStimulus(1'b1, v);
      end
      drainBeats(30, N);
      checkOutput("sat_n0", 32'(got_cnt[0]), 32'd255);
      checkOutput("sat_n1", 32'(got_cnt[1]), 32'd150);
      checkOutput("sat_n2", 32'(got_cnt[2]), 32'd0);

      $display("[TB] window of 4 with gapped spk_valid");
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      startWindow(4);
      for (int t = 0; t < 7; t++) begin
         v = '0;
         if (pat[t]) v[1] = 1'b1;
         else        v[5] = 1'b1;
         applyStimulus(pat[t], v);
      end
      checkOutput("gap_latency_valid", 32'(out_valid), 32'd0);
      checkOutput("gap_latency_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("gap_first_valid", 32'(out_valid), 32'd1);
      checkOutput("gap_first_idx", 32'(out_idx), 32'd0);
      drainBeats(100, N);
      checkOutput("gap_n1", 32'(got_cnt[1]), 32'd4);
      checkOutput("gap_n5", 32'(got_cnt[5]), 32'd0);

      $display("[TB] argmax tie between neurons 7 and 20");
      startWindow(9);
      for (int t = 0; t < 9; t++) begin
         v = '0;
         v[7]  = 1'b1;
         v[20] = 1'b1;
         if (t < 8) v[30] = 1'b1;
         applyStimulus(1'b1, v);
      end
      drainBeats(100, N);
      checkOutput("tie_n30", 32'(got_cnt[30]), 32'd8);
`ifdef SPK_ARGMAX_EN
      checkOutput("tie_widx", 32'(winner_idx), 32'd7);
      checkOutput("tie_wcnt", 32'(winner_count), 32'd9);
`else
      checkOutput("tie_widx", 32'(winner_idx), 32'd0);
      checkOutput("tie_wcnt", 32'(winner_count), 32'd0);
`endif

      $display("[TB] zero-length window");
      startWindow(0);
      drainBeats(100, N);
      checkOutput("zero_widx", 32'(winner_idx), 32'd0);
      checkOutput("zero_wcnt", 32'(winner_count), 32'd0);

      $display("[TB] reset during accumulation");
      startWindow(10);
      for (int t = 0; t < 3; t++) begin
         v = '0;
         v[3] = 1'b1;
         applyStimulus(1'b1, v);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("racc_busy", 32'(busy), 32'd0);
      checkOutput("racc_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      startWindow(2);
      for (int t = 0; t < 2; t++) begin
         v = '0;
         v[50] = 1'b1;
         applyStimulus(1'b1, v);
      end
      drainBeats(100, N);
      checkOutput("racc_n3", 32'(got_cnt[3]), 32'd0);
      checkOutput("racc_n50", 32'(got_cnt[50]), 32'd2);

      $display("[TB] reset during drain");
      startWindow(2);
      for (int t = 0; t < 2; t++) begin
         v = '0;
         v[60] = 1'b1;
         applyStimulus(1'b1, v);
      end
      drainBeats(100, 40);
      checkOutput("rdrn_pre_valid", 32'(out_valid), 32'd1);
      checkOutput("rdrn_pre_idx", 32'(out_idx), 32'd40);
      #2 rst = 1'b1;
      out_ready = 1'b0;
      #1;
      checkOutput("rdrn_valid", 32'(out_valid), 32'd0);
      checkOutput("rdrn_idx", 32'(out_idx), 32'd0);
      checkOutput("rdrn_count", 32'(out_count), 32'd0);
      checkOutput("rdrn_last", 32'(out_last), 32'd0);
      checkOutput("rdrn_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rdrn_quiet", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
      startWindow(1);
      v = '0;
      v[0] = 1'b1;
      applyStimulus(1'b1, v);
      drainBeats(100, N);
      checkOutput("rdrn_n60", 32'(got_cnt[60]), 32'd0);
      checkOutput("rdrn_n0", 32'(got_cnt[0]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spike_count_readout.md
Name: spike_count_readout

Overview:
- Downstream consumer of the SNN core's per-tick spike vector.
- Accumulates per-neuron spike counts over a programmable window of valid ticks.
- After the window closes, streams the counts out one neuron per beat on a valid/ready interface.
- Optionally tracks the argmax neuron, which is used as the classification result.

Parameters:
- N, 96, number of neurons (width of spikes_vec).
- CW, 8, per-neuron count width; counts saturate at 2^CW-1.
- TW, 16, width of the window-length / tick counter.
- IW, $clog2(N), index width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a new window, honoured only in IDLE.
- win_len  in  TW  window length in valid ticks; sampled on accepted start.
- spk_valid  in  1  spikes_vec holds one tick's result this cycle.
- spikes_vec  in  N  per-neuron spike bits, bit n = neuron n.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  count beat valid.
- out_ready  in  1  downstream accepts beat.
- out_idx  out  IW  neuron index of current beat.
- out_count  out  CW  spike count of neuron out_idx.
- out_last  out  1  high on the beat with out_idx == N-1.
- win_done  out  1  one-cycle pulse when the readout completes.
- winner_idx  out  IW  argmax neuron (SPK_ARGMAX_EN only).
- winner_count  out  CW  count of the argmax neuron (SPK_ARGMAX_EN only).

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All counts and the tick counter are cleared.
  - busy, out_valid, out_last, win_done, out_idx, out_count, winner_idx and winner_count are all 0.
  - A reset mid-window or mid-drain discards everything; no partial beats follow.
- States: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 clears all N counts, latches win_len into len_q and zeroes tick_cnt.
  - Next state is ACCUM, or DRAIN directly if win_len==0 (all counts then read as 0).
- ACCUM:
  - Each cycle with spk_valid=1: counts[n] += spikes_vec[n] for all n in parallel, saturating at 2^CW-1, and tick_cnt++.
  - When the accepted tick is number len_q (tick_cnt == len_q-1 at that edge), next state is DRAIN with rd_idx=0.
  - spk_valid=0 cycles do not advance tick_cnt.
  - start is ignored.
- spk_valid in IDLE, DRAIN or DONE is ignored; spikes there are dropped.
- DRAIN:
  - Drives out_valid=1, out_idx=rd_idx, out_count=counts[rd_idx] (registered, no combinational path from out_ready to outputs).
  - On out_valid && out_ready: rd_idx++.
  - The beat with rd_idx==N-1 asserts out_last; its handshake moves the block to DONE.
  - out_valid never drops and out_idx/out_count never change while out_ready=0.
  - Latency: first beat appears 1 cycle after the ACCUM->DRAIN transition.
- DONE:
  - One cycle; win_done=1 and out_valid=0.
  - winner_* hold their final values until the next accepted start clears them.
  - Returns to IDLE.
- A start arriving in the same cycle as win_done is ignored; start must be issued after returning to IDLE.
- Widths: saturating add uses a CW+1 temporary; tick compare is unsigned TW bits.

Optional Feature:
- Macro SPK_ARGMAX_EN.
- Defined:
  - During DRAIN, each handshaked beat updates winner_idx/winner_count when out_count > winner_count (strict), so ties resolve to the lowest index.
  - Values are final when win_done pulses.
- Undefined:
  - winner_idx and winner_count are tied to 0.
  - No compare logic is instantiated.

Decomposition:
- Package snn_readout_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_DONE} readout_state_t.
  - Default constants N_DEF=96, CW_DEF=8, TW_DEF=16.
  - A sat_inc function (count, bit) -> count.
- Sub-module spike_argmax_tracker (compiled only under SPK_ARGMAX_EN):
  - Inputs: beat valid, idx, count, clear.
  - Outputs: winner_idx, winner_count.

Test Plan:
- win_len=5; neuron 3 spikes on all 5 ticks, neuron 10 on 2 ticks, others silent -> beat 3 count=5, beat 10 count=2, all others 0; 96 beats, out_last only at idx 95; win_done one cycle after last handshake.
- win_len=300, CW=8, neuron 0 spikes every tick -> count saturates at 255, no wrap; neighbour counts unaffected.
- win_len=4 with spk_valid toggling 1,0,0,1,1,0,1 -> exactly 4 ticks counted, DRAIN entered after the 4th valid tick; spikes presented during spk_valid=0 not counted.
- out_ready random 30% during DRAIN -> out_idx/out_count stable while stalled, no index skipped or repeated, exactly N beats.
- SPK_ARGMAX_EN, neurons 7 and 20 both reach count 9 (max) -> winner_idx=7, winner_count=9 at win_done; win_len=0 -> 96 zero beats, winner_idx=0, winner_count=0.
- rst asserted mid-ACCUM (tick 3 of 10) and mid-DRAIN (beat 40) -> outputs 0 asynchronously, state IDLE; a new start yields fresh counts with no residue.
